// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM state codes and the base byte-enable patterns used for lane placement.
package dmem_pkg;

  // Access size as presented on req_size; 2'd3 is handled like a word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Controller state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RD_WAIT = 2'd1;
  localparam state_t ST_WR_WAIT = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  // Byte-enable patterns for lane 0; shifted up to the addressed lane.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Load/store bus between the datapath, the access controller and the RAM.
// The datapath is the master, the controller the slave, the RAM sits on the
// mem_* side of the same bundle.
interface dmem_access_ctrl_if #(
  parameter int MEM_AW = 8
);
  logic              req;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic [31:0]       rdata;
  logic              misaligned;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_wren;
  logic [31:0]       mem_q;

  modport master (
    output req, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  stall, rdata, misaligned
  );

  modport slave (
    input  req, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
    output stall, rdata, misaligned, mem_addr, mem_wdata, mem_be, mem_wren
  );

  modport ram (
    input  mem_addr, mem_wdata, mem_be, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Purely combinational lane logic: positions store data and byte enables on
// the addressed lanes, extracts and extends load data from the RAM word, and
// flags accesses that are not naturally aligned.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] q,
  output logic [31:0] lane_wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] q_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate data across lanes and select the enabled lanes.
  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    lane_wdata = wdata;
    be         = BE_WORD;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        lane_wdata = {4{wdata[7:0]}};
        be         = BE_BYTE << byte_off;
      end
      SZ_HALF: begin
        lane_wdata = {2{wdata[15:0]}};
        be         = BE_HALF << {byte_off[1], 1'b0};
        misaligned = byte_off[0];
      end
      default: begin
        misaligned = (byte_off != 2'b00);
      end
    endcase
  end

  // Load side: pick the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    q_shift   = q >> {byte_off, 3'b000};
    ld_byte   = q_shift[7:0];
    ld_half   = byte_off[1] ? q[31:16] : q[15:0];
    load_data = q;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = q;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller. Sequences each aligned load or store through
// the synchronous RAM with configurable read/write latency, stalls the
// datapath until the access completes, and rejects misaligned accesses.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_AW = 8,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);
  localparam logic [2:0] WR_LAT_C = 3'(WR_LAT);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic [31:0] rdata_q;
  logic [31:0] rdata_nxt;
  logic [31:0] load_ext;
  logic        mis;
  logic        unused_addr_bits;

  dmem_lane_align u_lane (
    .size        (bus.req_size),
    .is_unsigned (bus.req_unsigned),
    .byte_off    (bus.req_addr[1:0]),
    .wdata       (bus.req_wdata),
    .q           (bus.mem_q),
    .lane_wdata  (bus.mem_wdata),
    .be          (bus.mem_be),
    .load_data   (load_ext),
    .misaligned  (mis)
  );

  // Address bits above the RAM depth are dropped, so accesses wrap.
  assign bus.mem_addr     = bus.req_addr[MEM_AW+1:2];
  assign unused_addr_bits = ^bus.req_addr[31:MEM_AW+2];

  // Handshake outputs; rdata is only presented while the access completes.
  assign bus.stall      = bus.req && !mis && (state != ST_DONE);
  assign bus.misaligned = bus.req && mis && (state == ST_IDLE);
  assign bus.mem_wren   = (state == ST_WR_WAIT);
  assign bus.rdata      = (state == ST_DONE) ? rdata_q : 32'h0;

  // Next-state logic: accept, count latency, capture load data, complete.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdata_nxt = rdata_q;
    case (state)
      ST_IDLE: begin
        if (bus.req && !mis) begin
          state_nxt = bus.req_we ? ST_WR_WAIT : ST_RD_WAIT;
          cnt_nxt   = 3'd1;
        end
      end
      ST_RD_WAIT: begin
        if (!bus.req) begin
          // Request withdrawn mid-access: abandon it without completing.
          state_nxt = ST_IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt == RD_LAT_C) begin
          rdata_nxt = load_ext;
          state_nxt = ST_DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      ST_WR_WAIT: begin
        if (!bus.req) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt == WR_LAT_C) begin
          state_nxt = ST_DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, latency counter and load-data register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      rdata_q <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rdata_q <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl. Two instances run side by
// side: u_a with RD_LAT=1/WR_LAT=1 and u_b with RD_LAT=3/WR_LAT=2, each backed
// by a small behavioural RAM with the matching read latency.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Results of the most recent access.
  int          tot;
  int          stl;
  int          wrn;
  int          wfst;
  logic [31:0] rd;

  dmem_access_ctrl_if #(.MEM_AW(8)) if_a ();
  dmem_access_ctrl_if #(.MEM_AW(8)) if_b ();

  dmem_access_ctrl #(.MEM_AW(8), .RD_LAT(1), .WR_LAT(1)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  dmem_access_ctrl #(.MEM_AW(8), .RD_LAT(3), .WR_LAT(2)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Behavioural RAMs: one-cycle and three-cycle read latency.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] qa;
  logic [31:0] qb1, qb2, qb3;

  always @(posedge clk) begin
    if (if_a.mem_wren) mem_a[if_a.mem_addr] <= merge(mem_a[if_a.mem_addr], if_a.mem_wdata, if_a.mem_be);
    qa <= mem_a[if_a.mem_addr];
  end
  assign if_a.mem_q = qa;

  always @(posedge clk) begin
    if (if_b.mem_wren) mem_b[if_b.mem_addr] <= merge(mem_b[if_b.mem_addr], if_b.mem_wdata, if_b.mem_be);
    qb1 <= mem_b[if_b.mem_addr];
    qb2 <= qb1;
    qb3 <= qb2;
  end
  assign if_b.mem_q = qb3;

  task automatic set_req(input bit inst, input logic rq, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (!inst) begin
      if_a.req = rq; if_a.req_we = we; if_a.req_size = size;
      if_a.req_unsigned = uns; if_a.req_addr = addr; if_a.req_wdata = wdata;
    end else begin
      if_b.req = rq; if_b.req_we = we; if_b.req_size = size;
      if_b.req_unsigned = uns; if_b.req_addr = addr; if_b.req_wdata = wdata;
    end
  endtask

  // Called early in the accepting cycle; samples each cycle on the falling
  // edge until stall drops, then returns just after the next rising edge
  // with the request still asserted. A 20-cycle budget bounds the wait.
  task automatic run_access(input bit inst);
    tot = 0; stl = 0; wrn = 0; wfst = -1; rd = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tot++;
      if (inst ? if_b.mem_wren : if_a.mem_wren) begin
        wrn++;
        if (wfst < 0) wfst = i;
      end
      if (inst ? if_b.stall : if_a.stall) stl++;
      else begin
        rd = inst ? if_b.rdata : if_a.rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_acc(input bit inst, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    set_req(inst, 1'b1, we, size, uns, addr, wdata);
    run_access(inst);
  endtask

  task automatic drop_all();
    set_req(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    checks++; if (if_a.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", if_a.stall); end
    checks++; if (if_a.misaligned !== 1'b0) begin errors++; $display("FAIL rst_misaligned: got %b expected 0", if_a.misaligned); end
    checks++; if (if_a.mem_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b expected 0", if_a.mem_wren); end
    checks++; if (if_a.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", if_a.rdata); end
    checks++; if (u_a.state !== ST_IDLE || u_a.cnt !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d/%0d expected 0/0", u_a.state, u_a.cnt); end
    set_req(1'b0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    checks++; if (if_a.stall !== 1'b1) begin errors++; $display("FAIL rst_stall_follows_req: got %b expected 1", if_a.stall); end
    checks++; if (if_a.mem_addr !== 8'h04) begin errors++; $display("FAIL rst_mem_addr: got %h expected 04", if_a.mem_addr); end
    drop_all();
    #1;
    checks++; if (if_a.stall !== 1'b0) begin errors++; $display("FAIL rst_stall_drop: got %b expected 0", if_a.stall); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    set_req(1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    #1;
    checks++; if (if_a.mem_be !== 4'b1111) begin errors++; $display("FAIL word_store_be: got %b expected 1111", if_a.mem_be); end
    run_access(1'b0);
    checks++; if (wrn !== 1 || wfst !== 1) begin errors++; $display("FAIL word_store_wren: got %0d cycles from %0d expected 1 from 1", wrn, wfst); end
    checks++; if (stl !== 2 || tot !== 3) begin errors++; $display("FAIL word_store_timing: got stall %0d total %0d expected 2/3", stl, tot); end
    checks++; if (mem_a[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_ram: got %h expected deadbeef", mem_a[4]); end
    do_acc(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_rdata: got %h expected deadbeef", rd); end
    checks++; if (stl !== 2 || tot !== 3 || wrn !== 0) begin errors++; $display("FAIL word_load_timing: got stall %0d total %0d wren %0d expected 2/3/0", stl, tot, wrn); end
  endtask

  task automatic test_subword();
    do_acc(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h80FF1234);
    do_acc(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_signed: got %h expected ffffff80", rd); end
    do_acc(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL byte_load_unsigned: got %h expected 00000080", rd); end
    set_req(1'b0, 1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000AB);
    #1;
    checks++; if (if_a.mem_be !== 4'b0010) begin errors++; $display("FAIL byte_store_be: got %b expected 0010", if_a.mem_be); end
    checks++; if (if_a.mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL byte_store_wdata: got %h expected abababab", if_a.mem_wdata); end
    run_access(1'b0);
    do_acc(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    checks++; if (rd !== 32'h80FFAB34) begin errors++; $display("FAIL byte_store_merge: got %h expected 80ffab34", rd); end
    do_acc(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
    checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL half_load_signed: got %h expected ffff80ff", rd); end
    do_acc(1'b0, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0);
    checks++; if (rd !== 32'h0000AB34) begin errors++; $display("FAIL half_load_unsigned: got %h expected 0000ab34", rd); end
    drop_all();
  endtask

  task automatic test_misaligned();
    set_req(1'b0, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0);
    #1;
    checks++; if (if_a.misaligned !== 1'b1) begin errors++; $display("FAIL mis_half_flag: got %b expected 1", if_a.misaligned); end
    checks++; if (if_a.stall !== 1'b0 || if_a.rdata !== 32'h0) begin errors++; $display("FAIL mis_half_stall_rdata: got %b/%h expected 0/0", if_a.stall, if_a.rdata); end
    @(posedge clk); #1;
    checks++; if (u_a.state !== ST_IDLE) begin errors++; $display("FAIL mis_half_state: got %0d expected 0", u_a.state); end
    drop_all();
    #1;
    checks++; if (if_a.misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b expected 0", if_a.misaligned); end
    set_req(1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h12, 32'hFFFFFFFF);
    #1;
    checks++; if (if_a.misaligned !== 1'b1 || if_a.mem_wren !== 1'b0) begin errors++; $display("FAIL mis_word_store: got mis %b wren %b expected 1/0", if_a.misaligned, if_a.mem_wren); end
    @(posedge clk); #1;
    checks++; if (if_a.mem_wren !== 1'b0 || u_a.state !== ST_IDLE) begin errors++; $display("FAIL mis_word_no_access: got wren %b state %0d expected 0/0", if_a.mem_wren, u_a.state); end
    drop_all();
    @(posedge clk); #1;
    do_acc(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    checks++; if (rd !== 32'h80FFAB34) begin errors++; $display("FAIL mis_ram_untouched: got %h expected 80ffab34", rd); end
    drop_all();
  endtask

  task automatic test_latency();
    do_acc(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
    checks++; if (wrn !== 2 || wfst !== 1) begin errors++; $display("FAIL lat_store_wren: got %0d cycles from %0d expected 2 from 1", wrn, wfst); end
    checks++; if (stl !== 3 || tot !== 4) begin errors++; $display("FAIL lat_store_timing: got stall %0d total %0d expected 3/4", stl, tot); end
    do_acc(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    checks++; if (stl !== 4 || tot !== 5) begin errors++; $display("FAIL lat_load_timing: got stall %0d total %0d expected 4/5", stl, tot); end
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lat_load_rdata: got %h expected 11223344", rd); end
    drop_all();
  endtask

  task automatic test_reset_mid();
    set_req(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h24, 32'hCAFEF00D);
    @(posedge clk); #1;
    checks++; if (if_b.mem_wren !== 1'b1) begin errors++; $display("FAIL rstmid_wren_before: got %b expected 1", if_b.mem_wren); end
    reset = 1'b1;
    #1;
    checks++; if (if_b.mem_wren !== 1'b0) begin errors++; $display("FAIL rstmid_wren_async: got %b expected 0", if_b.mem_wren); end
    checks++; if (u_b.state !== ST_IDLE || u_b.rdata_q !== 32'h0) begin errors++; $display("FAIL rstmid_state: got %0d/%h expected 0/0", u_b.state, u_b.rdata_q); end
    drop_all();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_acc(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    checks++; if (rd !== 32'h11223344 || tot !== 5) begin errors++; $display("FAIL rstmid_next_load: got %h in %0d expected 11223344 in 5", rd, tot); end
    do_acc(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h24, 32'hCAFEF00D);
    do_acc(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_restore: got %h expected cafef00d", rd); end
    drop_all();
  endtask

  task automatic test_req_drop();
    set_req(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h28, 32'h0BADF00D);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h28, 32'h0BADF00D);
    @(posedge clk); #1;
    checks++; if (u_b.state !== ST_IDLE || if_b.mem_wren !== 1'b0) begin errors++; $display("FAIL drop_abort: got state %0d wren %b expected 0/0", u_b.state, if_b.mem_wren); end
  endtask

  task automatic test_wrap();
    set_req(1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h400, 32'h5A5A0001);
    #1;
    checks++; if (if_a.mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_mem_addr: got %h expected 00", if_a.mem_addr); end
    run_access(1'b0);
    do_acc(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    checks++; if (rd !== 32'h5A5A0001) begin errors++; $display("FAIL wrap_readback: got %h expected 5a5a0001", rd); end
    drop_all();
  endtask

  task automatic test_back_to_back();
    int start;
    logic [31:0] r0, r1;
    start = cyc;
    do_acc(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h00000111);
    do_acc(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h44, 32'h00000222);
    do_acc(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    r0 = rd;
    do_acc(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0);
    r1 = rd;
    drop_all();
    checks++; if (cyc - start !== 12) begin errors++; $display("FAIL b2b_cycles: got %0d expected 12", cyc - start); end
    checks++; if (r0 !== 32'h00000111 || r1 !== 32'h00000222) begin errors++; $display("FAIL b2b_data: got %h/%h expected 00000111/00000222", r0, r1); end
  endtask

  initial begin
    reset = 1'b1;
    drop_all();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_latency();
    test_reset_mid();
    test_req_drop();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
